// File: rtl/seg_scan_decoder_if.sv
// Scan-bus bundle between a seven-segment display driver (master) and the scan decoder (slave).
// Carries the segment/digit-select inputs and the published value/strobe outputs.
interface seg_scan_decoder_if;
    logic [6:0]  OL;
    logic [3:0]  DIG;
    logic [13:0] value;
    logic [15:0] bcd;
    logic        value_valid;
    logic        frame_err;

    modport master (
        output OL, DIG,
        input  value, bcd, value_valid, frame_err
    );

    modport slave (
        input  OL, DIG,
        output value, bcd, value_valid, frame_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Decodes a 4-digit multiplexed seven-segment scan bus back to binary and BCD values.
// Optional macro SEG_CONFIRM_EN: publish only when two consecutive completed frames agree.
module seg_scan_decoder #(
    parameter bit SEG_INV = 1'b0
) (
    input  logic                clk_16k,
    input  logic                rst,
    seg_scan_decoder_if.slave   bus,
    output logic [1:0]          state_dbg_o
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        EXP_H = 2'd1,
        EXP_T = 2'd2,
        EXP_O = 2'd3
    } state_t;

    // Returns {valid, digit}; anything outside the ten legal glyphs is invalid.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = {1'b1, 4'd0};
            7'b0110000: r = {1'b1, 4'd1};
            7'b1101101: r = {1'b1, 4'd2};
            7'b1111001: r = {1'b1, 4'd3};
            7'b0110011: r = {1'b1, 4'd4};
            7'b1011011: r = {1'b1, 4'd5};
            7'b1011111: r = {1'b1, 4'd6};
            7'b1110000: r = {1'b1, 4'd7};
            7'b1111111: r = {1'b1, 4'd8};
            7'b1111011: r = {1'b1, 4'd9};
            default:    r = 5'd0;
        endcase
        return r;
    endfunction

    logic [6:0]  ol_q;
    logic [3:0]  dig_q;
    logic [6:0]  hist_ol_q;
    logic [3:0]  hist_dig_q;
    logic        hist_vld_q;
    state_t      state_q, state_d;
    logic [15:0] digs_q, digs_d;
    logic [13:0] value_q, value_d;
    logic [15:0] bcd_q, bcd_d;
    logic        vv_q, vv_d;
    logic        fe_q, fe_d;
`ifdef SEG_CONFIRM_EN
    logic [15:0] cand_q, cand_d;
    logic        cand_vld_q, cand_vld_d;
`endif

    logic [6:0]  seg_n;
    logic [4:0]  dec;
    logic        pat_vld;
    logic [3:0]  pat_dig;
    logic        is_hold;
    logic        is_start;
    logic [3:0]  exp_dig;
    logic [15:0] frame_bcd;
    logic [13:0] frame_value;
    logic        frame_done;
    logic        publish;

    assign seg_n    = SEG_INV ? ~ol_q : ol_q;
    assign dec      = decode_seg(seg_n);
    assign pat_vld  = dec[4];
    assign pat_dig  = dec[3:0];
    assign is_hold  = hist_vld_q && (dig_q == hist_dig_q) && (ol_q == hist_ol_q);
    assign is_start = (dig_q == 4'b1000) && pat_vld;

    assign frame_bcd   = {digs_q[15:4], pat_dig};
    assign frame_value = 14'(frame_bcd[15:12]) * 14'd1000
                       + 14'(frame_bcd[11:8])  * 14'd100
                       + 14'(frame_bcd[7:4])   * 14'd10
                       + 14'(frame_bcd[3:0]);

    always_comb begin
        exp_dig = 4'b0000;
        case (state_q)
            EXP_H:   exp_dig = 4'b0100;
            EXP_T:   exp_dig = 4'b0010;
            EXP_O:   exp_dig = 4'b0001;
            default: exp_dig = 4'b1000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        digs_d     = digs_q;
        value_d    = value_q;
        bcd_d      = bcd_q;
        vv_d       = 1'b0;
        fe_d       = 1'b0;
        frame_done = 1'b0;
        publish    = 1'b0;
`ifdef SEG_CONFIRM_EN
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
`endif

        if (state_q == SYNC) begin
            if (is_start) begin
                digs_d  = {pat_dig, 12'h000};
                state_d = EXP_H;
            end
        end else if (!is_hold) begin
            if ((dig_q == exp_dig) && pat_vld) begin
                case (state_q)
                    EXP_H: begin
                        digs_d[11:8] = pat_dig;
                        state_d      = EXP_T;
                    end
                    EXP_T: begin
                        digs_d[7:4] = pat_dig;
                        state_d     = EXP_O;
                    end
                    default: begin
                        digs_d[3:0] = pat_dig;
                        frame_done  = 1'b1;
                        state_d     = SYNC;
                    end
                endcase
            end else begin
                // Partial frame is dropped; a valid thousands sample restarts immediately.
                fe_d = 1'b1;
`ifdef SEG_CONFIRM_EN
                cand_vld_d = 1'b0;
`endif
                if (is_start) begin
                    digs_d  = {pat_dig, 12'h000};
                    state_d = EXP_H;
                end else begin
                    state_d = SYNC;
                end
            end
        end

        if (frame_done) begin
`ifdef SEG_CONFIRM_EN
            publish    = cand_vld_q && (cand_q == frame_bcd);
            cand_d     = frame_bcd;
            cand_vld_d = 1'b1;
`else
            publish = 1'b1;
`endif
        end

        if (publish) begin
            value_d = frame_value;
            bcd_d   = frame_bcd;
            vv_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_16k or posedge rst) begin
        if (rst) begin
            ol_q       <= 7'd0;
            dig_q      <= 4'd0;
            hist_ol_q  <= 7'd0;
            hist_dig_q <= 4'd0;
            hist_vld_q <= 1'b0;
            state_q    <= SYNC;
            digs_q     <= 16'h0000;
            value_q    <= 14'd0;
            bcd_q      <= 16'h0000;
            vv_q       <= 1'b0;
            fe_q       <= 1'b0;
`ifdef SEG_CONFIRM_EN
            cand_q     <= 16'h0000;
            cand_vld_q <= 1'b0;
`endif
        end else begin
            ol_q       <= bus.OL;
            dig_q      <= bus.DIG;
            hist_ol_q  <= ol_q;
            hist_dig_q <= dig_q;
            hist_vld_q <= 1'b1;
            state_q    <= state_d;
            digs_q     <= digs_d;
            value_q    <= value_d;
            bcd_q      <= bcd_d;
            vv_q       <= vv_d;
            fe_q       <= fe_d;
`ifdef SEG_CONFIRM_EN
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
`endif
        end
    end

    assign bus.value       = value_q;
    assign bus.bcd         = bcd_q;
    assign bus.value_valid = vv_q;
    assign bus.frame_err   = fe_q;
    assign state_dbg_o     = state_q;

endmodule
